ps2_key_rx: RTL and testbench

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 203 ++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: glitch-filtered clock, 11-bit frame decoder and
// scan-code prefix handling (E0 extended, F0 break, E1 pause skip) into a toggle-flagged key word.
module ps2_key_rx #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 65535
) (
    input  logic        MCLK,
    input  logic        RESET_N,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [10:0] KEY,
    output logic        ERR
);

    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILT_LEN - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_PAUSE = 8'hE1;
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic          clk_meta;
    logic          clk_sync;
    logic          dat_meta;
    logic          dat_sync;

    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          filt_flip;
    logic          fall;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nxt;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nxt;
    logic          par_bit;
    logic          par_bit_nxt;
    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_nxt;
    logic          byte_ok;
    logic          frame_err;
    logic          timeout_hit;

    logic          ext_flag;
    logic          brk_flag;
    logic [2:0]    skip_cnt;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= PS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= PS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // The filtered level flips on the FILT_LEN-th consecutive opposite sample;
    // that same cycle is the one in which data is sampled on a falling flip.
    assign filt_flip = (clk_sync != filt_clk) && (filt_cnt == FILT_LAST);
    assign fall      = filt_flip && filt_clk;

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_flip) begin
            filt_clk <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_bit_nxt;
            to_cnt  <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        to_cnt_nxt  = to_cnt;
        byte_ok     = 1'b0;
        frame_err   = 1'b0;
        timeout_hit = 1'b0;

        // A falling edge restarts the idle count, so it can never coincide with a timeout.
        if (state == S_IDLE || fall) begin
            to_cnt_nxt = '0;
        end else if (to_cnt == TO_LAST) begin
            timeout_hit = 1'b1;
            state_nxt   = S_IDLE;
            bit_cnt_nxt = '0;
            to_cnt_nxt  = '0;
        end else begin
            to_cnt_nxt = to_cnt + 1'b1;
        end

        if (fall) begin
            case (state)
                S_IDLE: begin
                    if (!dat_sync) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shreg_nxt   = {dat_sync, shreg[7:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = S_PARITY;
                    end
                end
                S_PARITY: begin
                    par_bit_nxt = dat_sync;
                    state_nxt   = S_STOP;
                end
                S_STOP: begin
                    state_nxt   = S_IDLE;
                    bit_cnt_nxt = '0;
                    if (dat_sync && (^{shreg, par_bit})) begin
                        byte_ok = 1'b1;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge MCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            KEY      <= '0;
            ERR      <= 1'b0;
            ext_flag <= 1'b0;
            brk_flag <= 1'b0;
            skip_cnt <= '0;
        end else begin
            ERR <= frame_err | timeout_hit;
            if (frame_err || timeout_hit) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
                skip_cnt <= '0;
            end else if (byte_ok) begin
                // Pause tail bytes are swallowed whatever their value.
                if (skip_cnt != '0) begin
                    skip_cnt <= skip_cnt - 1'b1;
                end else begin
                    case (shreg)
                        B_PAUSE: skip_cnt <= PAUSE_TAIL;
                        B_EXT:   ext_flag <= 1'b1;
                        B_BRK:   brk_flag <= 1'b1;
                        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                        default: begin
                            KEY      <= {~KEY[10], ~brk_flag, ext_flag, shreg};
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed PS/2 frames; expected key words and error
// pulses, with their latency from the last driven clock fall, go through a scoreboard.
module tb_ps2_key_rx;

    localparam int FILT = 8;
    localparam int TOUT = 1000;
    localparam int HALF = 20;
    localparam int LAT  = FILT + 2;

    logic        MCLK    = 1'b0;
    logic        RESET_N = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [10:0] KEY;
    logic        ERR;

    typedef struct {
        bit          is_err;
        logic [10:0] key;
        int          delay;
    } exp_t;

    exp_t        sb[$];
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          last_fall = 0;
    logic [10:0] last_key;

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    ps2_key_rx #(
        .FILT_LEN(FILT),
        .TIMEOUT (TOUT)
    ) dut (
        .MCLK   (MCLK),
        .RESET_N(RESET_N),
        .PS2_CLK(PS2_CLK),
        .PS2_DAT(PS2_DAT),
        .KEY    (KEY),
        .ERR    (ERR)
    );

    task automatic expect_key(input logic [10:0] k);
        exp_t e;
        e.is_err = 1'b0;
        e.key    = k;
        e.delay  = LAT;
        sb.push_back(e);
    endtask

    task automatic expect_err(input int d);
        exp_t e;
        e.is_err = 1'b1;
        e.key    = '0;
        e.delay  = d;
        sb.push_back(e);
    endtask

    task automatic check_event(input bit is_err, input logic [10:0] k);
        exp_t e;
        int   d;
        d = cyc - last_fall;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got err=%0b key=%03h delay=%0d required none", is_err, k, d);
        end else begin
            e = sb.pop_front();
            if (e.is_err != is_err || (!is_err && e.key != k) || d != e.delay) begin
                failures++;
                $display("FAIL event got err=%0b key=%03h delay=%0d required err=%0b key=%03h delay=%0d",
                         is_err, k, d, e.is_err, e.key, e.delay);
            end
        end
    endtask

    task automatic ps2_bit(input logic d, input bit glitch);
        @(negedge MCLK);
        PS2_DAT = d;
        if (glitch) begin
            repeat (4) @(negedge MCLK);
            PS2_CLK = 1'b0;
            repeat (5) @(negedge MCLK);
            PS2_CLK = 1'b1;
            repeat (HALF - 9) @(negedge MCLK);
        end else begin
            repeat (HALF) @(negedge MCLK);
        end
        PS2_CLK   = 1'b0;
        last_fall = cyc;
        repeat (HALF) @(negedge MCLK);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
        logic par;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0, glitch);
        for (int unsigned i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit(par, glitch);
        ps2_bit(!bad_stop, glitch);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge MCLK);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge MCLK);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_%s pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        repeat (5) @(negedge MCLK);
    endtask

    initial begin
        last_key = '0;
        fork
            forever begin
                @(negedge MCLK);
                if (!RESET_N) begin
                    last_key = KEY;
                end else begin
                    if (ERR || KEY != last_key) begin
                        checks++;
                        if (ERR && KEY != last_key) begin
                            failures++;
                            $display("FAIL err_with_key got err=1 key=%03h required no overlap", KEY);
                        end
                    end
                    if (KEY != last_key) check_event(1'b0, KEY);
                    if (ERR) check_event(1'b1, KEY);
                    last_key = KEY;
                end
            end
        join_none

        repeat (5) @(negedge MCLK);
        checks++;
        if (KEY !== 11'h000) begin failures++; $display("FAIL reset_key got=%03h required=000", KEY); end
        checks++;
        if (ERR !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b required=0", ERR); end
        RESET_N = 1'b1;
        repeat (10) @(negedge MCLK);

        expect_key(11'h61C); good(8'h1C);
        wait_drain("basic");

        good(8'hE0); good(8'hF0);
        expect_key(11'h175); good(8'h75);
        wait_drain("ext_break");

        expect_err(LAT); send_frame(8'h29, 1'b1, 1'b0, 1'b0);
        expect_key(11'h629); good(8'h29);
        wait_drain("parity");

        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b1, 1'b0);
        expect_err(LAT + TOUT);
        wait_drain("timeout");
        PS2_DAT = 1'b1;
        ps2_bit(1'b1, 1'b0);
        expect_key(11'h216); good(8'h16);
        wait_drain("after_timeout");

        @(negedge MCLK);
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        repeat (5) @(negedge MCLK);
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge MCLK);
        expect_key(11'h61C); send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
        wait_drain("glitch");

        good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
        good(8'hF0); good(8'h14); good(8'hF0); good(8'h77);
        expect_key(11'h205); good(8'h05);
        wait_drain("pause");

        expect_key(11'h605); good(8'h05);
        expect_key(11'h205); good(8'h05);
        wait_drain("typematic");

        good(8'hE0); good(8'hAA);
        expect_key(11'h61C); good(8'h1C);
        good(8'hF0); good(8'hFA);
        expect_key(11'h21C); good(8'h1C);
        wait_drain("discard");

        good(8'hE0);
        expect_err(LAT); send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        expect_key(11'h61C); good(8'h1C);
        wait_drain("stop_err");

        good(8'hE1); good(8'h14);
        expect_err(LAT); send_frame(8'h33, 1'b1, 1'b0, 1'b0);
        expect_key(11'h21C); good(8'h1C);
        wait_drain("skip_cancel");

        good(8'h00); good(8'hEE); good(8'hFE); good(8'hFF);
        expect_key(11'h65A); good(8'h5A);
        good(8'hE0); good(8'hF0); good(8'h00);
        expect_key(11'h25A); good(8'h5A);
        wait_drain("discard_all");

        ps2_bit(1'b0, 1'b0); ps2_bit(1'b1, 1'b0); ps2_bit(1'b0, 1'b0);
        @(negedge MCLK);
        RESET_N = 1'b0;
        repeat (3) @(negedge MCLK);
        checks++;
        if (KEY !== 11'h000) begin failures++; $display("FAIL midreset_key got=%03h required=000", KEY); end
        checks++;
        if (ERR !== 1'b0) begin failures++; $display("FAIL midreset_err got=%0b required=0", ERR); end
        RESET_N = 1'b1;
        repeat (10) @(negedge MCLK);
        expect_key(11'h61C); good(8'h1C);
        wait_drain("after_reset");

        repeat (50) @(negedge MCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
